// File: rtl/int_arbiter_if.sv
// Interrupt arbiter bus: device requests, mask writes and the
// ControlUnit handshake (INT/IntAck) with the vector returned on DATA.
interface int_arbiter_if #(
  parameter int N_SRC = 4
);
  localparam int IDW = $clog2(N_SRC);

  logic [N_SRC-1:0] IntReq;
  logic [31:0]      Bus_In;
  logic             LdMask;
  logic             IntAck;
  logic             INT;
  logic [31:0]      DATA;
  logic [N_SRC-1:0] Pending;
  logic [IDW-1:0]   ActiveId;

  modport master (
    output IntReq,
    output Bus_In,
    output LdMask,
    output IntAck,
    input  INT,
    input  DATA,
    input  Pending,
    input  ActiveId
  );

  modport slave (
    input  IntReq,
    input  Bus_In,
    input  LdMask,
    input  IntAck,
    output INT,
    output DATA,
    output Pending,
    output ActiveId
  );
endinterface

// File: rtl/int_arbiter.sv
// Multi-source interrupt arbiter: edge capture, mask, fixed/rr pick.
// Ports: CLK, RST (async high), bus (slave: IntReq/Bus_In/LdMask/IntAck in; INT/DATA/Pending/ActiveId out).
module int_arbiter #(
  parameter int          N_SRC       = 4,
  parameter logic [31:0] VEC_BASE    = 32'h0,
  parameter logic [31:0] VEC_STRIDE  = 32'h1,
  parameter bit          ROUND_ROBIN = 1'b0
) (
  input logic           CLK,
  input logic           RST,
  int_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(N_SRC);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] pend_q;
  logic [N_SRC-1:0] pend_d;
  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] clr;
  logic [IDW-1:0]   aid_q;
  logic [IDW-1:0]   aid_d;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   ptr_d;
  logic [IDW-1:0]   win;
  logic             win_vld;
  logic [31:0]      data_q;
  logic [31:0]      data_d;
  logic             int_q;
  logic             unused_bus;

  assign unused_bus = ^bus.Bus_In[31:N_SRC];

  assign rise = bus.IntReq & ~prev_q;
  assign elig = pend_q & mask_q;

  // k-th candidate in scan order; rr scans from the pointer
  function automatic logic [IDW-1:0] scan(
    input logic [IDW-1:0] p,
    input int             k
  );
    int s;
    s = k;
    if (ROUND_ROBIN) s = s + int'(p);
    if (s >= N_SRC) s = s - N_SRC;
    return IDW'(s);
  endfunction

  function automatic logic [31:0] vec(
    input logic [IDW-1:0] id
  );
    return VEC_BASE + 32'(id) * VEC_STRIDE;
  endfunction

  // Reverse scan so the first hit in priority order wins
  always_comb begin
    win     = '0;
    win_vld = |elig;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (elig[scan(ptr_q, k)]) begin
        win = scan(ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    aid_d   = aid_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          aid_d   = win;
          state_d = REQ;
        end
      end
      REQ: begin
        // ack beats a same-cycle withdrawal
        if (bus.IntAck) begin
          data_d  = vec(aid_q);
          clr     = N_SRC'(1) << aid_q;
          state_d = HOLD;
          if (aid_q == IDW'(N_SRC - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = aid_q + 1'b1;
          end
        end else if (!elig[aid_q]) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // a rise in the ack cycle re-arms the source
    pend_d = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      prev_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '1;
      aid_q   <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= bus.IntReq;
      pend_q  <= pend_d;
      aid_q   <= aid_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      int_q   <= (state_d == REQ);
      if (bus.LdMask) begin
        mask_q <= bus.Bus_In[N_SRC-1:0];
      end
    end
  end

  assign bus.INT      = int_q;
  assign bus.DATA     = data_q;
  assign bus.Pending  = pend_q;
  assign bus.ActiveId = aid_q;
endmodule

// File: tb/tb_int_arbiter.sv
// Bench for int_arbiter: fixed and round-robin instances share one
// stimulus stream and are compared each cycle against a reference.
module tb_int_arbiter;
  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_HOLD = 2;

  logic        CLK;
  logic        RST;
  logic [3:0]  req;
  logic [31:0] bus_in;
  logic        ld;
  logic        ack;

  int n_chk;
  int n_err;

  int_arbiter_if #(.N_SRC(4)) if0 ();
  int_arbiter_if #(.N_SRC(4)) if1 ();

  assign if0.IntReq = req;
  assign if0.Bus_In = bus_in;
  assign if0.LdMask = ld;
  assign if0.IntAck = ack;
  assign if1.IntReq = req;
  assign if1.Bus_In = bus_in;
  assign if1.LdMask = ld;
  assign if1.IntAck = ack;

  int_arbiter #(
    .N_SRC(4),
    .VEC_BASE(32'h0),
    .VEC_STRIDE(32'h1),
    .ROUND_ROBIN(1'b0)
  ) u_fix (
    .CLK(CLK),
    .RST(RST),
    .bus(if0.slave)
  );

  int_arbiter #(
    .N_SRC(4),
    .VEC_BASE(32'h100),
    .VEC_STRIDE(32'h10),
    .ROUND_ROBIN(1'b1)
  ) u_rr (
    .CLK(CLK),
    .RST(RST),
    .bus(if1.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // reference state, index 0 = fixed, 1 = round robin
  int       ph   [2];
  bit [3:0] pend [2];
  bit [3:0] mask [2];
  bit [3:0] prev [2];
  int       aid  [2];
  int       ptr  [2];
  bit [31:0] data[2];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(bit [3:0] e, int p, bit rr);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = rr ? (p + k) % 4 : k;
      if (e[i]) return i;
    end
    return 0;
  endfunction

  function automatic bit [31:0] vec(int m, int id);
    if (m == 0) return 32'(id);
    return 32'h100 + 32'(id) * 32'h10;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      ph[m]   = P_IDLE;
      pend[m] = 4'h0;
      mask[m] = 4'hF;
      prev[m] = 4'h0;
      aid[m]  = 0;
      ptr[m]  = 0;
      data[m] = 32'h0;
    end
  endtask

  task automatic model_step();
    bit [3:0] e;
    bit [3:0] r;
    bit [3:0] keep;
    if (RST) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      e    = pend[m] & mask[m];
      r    = req & ~prev[m];
      keep = pend[m];
      case (ph[m])
        P_IDLE: begin
          if (e != 0) begin
            aid[m] = pick(e, ptr[m], m == 1);
            ph[m]  = P_REQ;
          end
        end
        P_REQ: begin
          if (ack) begin
            data[m]      = vec(m, aid[m]);
            keep[aid[m]] = 1'b0;
            ptr[m]       = (aid[m] + 1) % 4;
            ph[m]        = P_HOLD;
          end else if (!e[aid[m]]) begin
            ph[m] = P_IDLE;
          end
        end
        default: ph[m] = P_IDLE;
      endcase
      pend[m] = keep | r;
      if (ld) mask[m] = bus_in[3:0];
      prev[m] = req;
    end
  endtask

  task automatic check_all();
    chk("f_int", 32'(if0.INT), 32'(ph[0] == P_REQ));
    chk("f_data", if0.DATA, data[0]);
    chk("f_pend", 32'(if0.Pending), 32'(pend[0]));
    chk("f_aid", 32'(if0.ActiveId), 32'(aid[0]));
    chk("r_int", 32'(if1.INT), 32'(ph[1] == P_REQ));
    chk("r_data", if1.DATA, data[1]);
    chk("r_pend", 32'(if1.Pending), 32'(pend[1]));
    chk("r_aid", 32'(if1.ActiveId), 32'(aid[1]));
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_step();
    #1;
    check_all();
  endtask

  task automatic async_rst();
    #2 RST = 1'b1;
    #1;
    model_reset();
    check_all();
    cycle();
    RST = 1'b0;
  endtask

  initial begin
    int got;
    int n;
    n_chk  = 0;
    n_err  = 0;
    req    = 4'h0;
    bus_in = 32'h0;
    ld     = 1'b0;
    ack    = 1'b0;
    RST    = 1'b1;
    #1;
    model_reset();
    chk("t1_int", 32'(if0.INT), 32'h0);
    chk("t1_data", if0.DATA, 32'h0);
    chk("t1_pend", 32'(if0.Pending), 32'h0);
    chk("t1_aid", 32'(if0.ActiveId), 32'h0);
    check_all();
    cycle();
    RST = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk("t1_quiet", 32'(if0.INT), 32'h0);

    // single event on source 2
    req = 4'b0100;
    cycle();
    req = 4'b0000;
    cycle();
    chk("t2_int", 32'(if0.INT), 32'h1);
    chk("t2_aid", 32'(if0.ActiveId), 32'h2);
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    chk("t2_data", if0.DATA, 32'h2);
    chk("t2_pend", 32'(if0.Pending), 32'h0);
    chk("t2_hold", 32'(if0.INT), 32'h0);
    cycle();
    cycle();
    chk("t2_low", 32'(if0.INT), 32'h0);

    // fixed priority between 3 and 1
    req = 4'b1010;
    cycle();
    req = 4'b0000;
    cycle();
    chk("t3_aid1", 32'(if0.ActiveId), 32'h1);
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    chk("t3_data1", if0.DATA, 32'h1);
    cycle();
    cycle();
    chk("t3_int", 32'(if0.INT), 32'h1);
    chk("t3_aid3", 32'(if0.ActiveId), 32'h3);
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    chk("t3_data3", if0.DATA, 32'h3);
    cycle();

    // round robin order 0,1,0,1
    async_rst();
    req = 4'b0011;
    cycle();
    req = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      n = 0;
      while (if1.INT !== 1'b1 && n < 8) begin
        cycle();
        n++;
      end
      chk("t4_req", 32'(if1.INT), 32'h1);
      chk("t4_order", 32'(if1.ActiveId), 32'(j % 2));
      got = int'(if1.ActiveId);
      ack = 1'b1;
      cycle();
      ack = 1'b0;
      req = 4'(1 << got);
      cycle();
      req = 4'b0000;
    end
    cycle();

    // mask withdrawal and re-enable
    async_rst();
    req = 4'b0010;
    cycle();
    req = 4'b0000;
    cycle();
    chk("t5_req", 32'(if0.INT), 32'h1);
    ld     = 1'b1;
    bus_in = 32'h0;
    cycle();
    ld = 1'b0;
    cycle();
    chk("t5_drop", 32'(if0.INT), 32'h0);
    chk("t5_pend", 32'(if0.Pending), 32'h2);
    ld     = 1'b1;
    bus_in = 32'hF;
    cycle();
    ld = 1'b0;
    cycle();
    chk("t5_again", 32'(if0.INT), 32'h1);
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    chk("t5_data", if0.DATA, 32'h1);
    cycle();

    // rise races ack, then reset during REQ
    async_rst();
    req = 4'b0001;
    cycle();
    req = 4'b0000;
    cycle();
    ack = 1'b1;
    req = 4'b0001;
    cycle();
    ack = 1'b0;
    req = 4'b0000;
    chk("t6_pend", 32'(if0.Pending), 32'h1);
    chk("t6_data", if1.DATA, 32'h100);
    cycle();
    cycle();
    chk("t6_reint", 32'(if0.INT), 32'h1);
    #2 RST = 1'b1;
    #1;
    chk("t6_rst_int", 32'(if0.INT), 32'h0);
    chk("t6_rst_pend", 32'(if0.Pending), 32'h0);
    chk("t6_rst_rint", 32'(if1.INT), 32'h0);
    model_reset();
    check_all();
    cycle();
    RST = 1'b0;

    // random traffic
    for (int i = 0; i < 600; i++) begin
      req    = 4'($urandom);
      ld     = ($urandom_range(0, 15) == 0);
      bus_in = ($urandom_range(0, 1) == 1) ? $urandom : 32'hF;
      ack    = ($urandom_range(0, 2) == 0);
      cycle();
      if ($urandom_range(0, 99) == 0) async_rst();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end
endmodule
